memory_writeback_cycle: RTL and testbench

- Back end of the 18-bit pipeline: receives the execute/memory-stage bundle, performs data-memory loads/stores over a req/ack handshake and drives the register-file write port (RegWriteW, RDW, ResultW) consumed by decode_cycle.
- Multi-cycle memory is absorbed by a small FSM that stalls upstream.
- A timeout counter aborts hung accesses.

---
 rtl/memory_writeback_cycle.sv | 159 +++++++++++++++
 tb/tb_memory_writeback_cycle.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback_cycle.sv
// memory_writeback_cycle
//   Back end of the 18-bit pipeline. Takes the M-stage bundle, performs
//   data-memory loads and stores over a req/ack handshake and drives the
//   register-file write port used by decode. A two-state FSM absorbs
//   multi-cycle memory by stalling upstream. A timeout counter aborts
//   accesses that never see an ack.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   valid_m          M stage holds a real instruction
//   RegWriteM        instruction writes a register
//   MemWriteM        store (wins if ResultSrcM is also set)
//   ResultSrcM       1 = load, 0 = ALU result
//   RD_M             destination register
//   ALUResultM       ALU result, low ADDR_W bits form the memory address
//   WriteDataM       store data
//   StallM           upstream must hold the M inputs
//   mem_req/mem_we   memory request / write strobe
//   mem_addr/wdata   latched address and store data
//   mem_rdata/ack    load data (valid with ack) / access complete
//   RegWriteW/RDW    register-file write enable / address
//   ResultW          register-file write data
//   err_o            one-cycle pulse when an access times out
module memory_writeback_cycle #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 18,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              RegWriteW,
    output logic [4:0]        RDW,
    output logic [DATA_W-1:0] ResultW,
    output logic              err_o
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        memop;
    logic        timeout_hit;
    logic        stall_raw;
    logic [7:0]  count;
    logic        lat_regwrite;
    logic [4:0]  lat_rd;

    assign memop       = valid_m & (MemWriteM | ResultSrcM);
    assign timeout_hit = (count == 8'(TIMEOUT - 1));

    // Reset forces the stall low immediately, even if upstream still
    // presents a memory op while the FSM sits in IDLE.
    assign StallM = rst & stall_raw;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall. The stall drops in the ack cycle and in the
    // final timeout cycle so upstream advances in step with the writeback.
    always_comb begin
        state_next = state;
        stall_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    state_next = ACCESS;
                    stall_raw  = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    state_next = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: memory interface registers, the writeback port and the
    // timeout counter. RegWriteW and err_o default low so each is a single
    // cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            RegWriteW    <= 1'b0;
            RDW          <= '0;
            ResultW      <= '0;
            err_o        <= 1'b0;
            count        <= '0;
            lat_regwrite <= 1'b0;
            lat_rd       <= '0;
        end else begin
            RegWriteW <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (memop) begin
                        mem_addr     <= ALUResultM[ADDR_W-1:0];
                        mem_wdata    <= WriteDataM;
                        mem_we       <= MemWriteM;
                        lat_regwrite <= RegWriteM;
                        lat_rd       <= RD_M;
                        mem_req      <= 1'b1;
                        count        <= '0;
                    end else if (valid_m) begin
                        RegWriteW <= RegWriteM;
                        RDW       <= RD_M;
                        ResultW   <= ALUResultM;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            RegWriteW <= lat_regwrite;
                            RDW       <= lat_rd;
                            ResultW   <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        err_o   <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// tb_memory_writeback_cycle
//   Randomized and directed bench for memory_writeback_cycle. The driver
//   plays both upstream and data memory; for every instruction it works out
//   from the architectural rules whether a register write must retire and
//   with what value, and pushes that into a queue. An independent monitor
//   pops the queue on every RegWriteW pulse and counts err_o pulses.
module tb_memory_writeback_cycle;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 18;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid_m = 1'b0;
    logic              RegWriteM = 1'b0;
    logic              MemWriteM = 1'b0;
    logic              ResultSrcM = 1'b0;
    logic [4:0]        RD_M = '0;
    logic [DATA_W-1:0] ALUResultM = '0;
    logic [DATA_W-1:0] WriteDataM = '0;
    logic              StallM;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              RegWriteW;
    logic [4:0]        RDW;
    logic [DATA_W-1:0] ResultW;
    logic              err_o;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] val;
    } wb_t;

    wb_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  err_expected = 0;
    int  err_seen = 0;
    int  cycle = 0;
    int  last_wb = -100;
    int  prev_wb = -100;
    logic err_prev = 1'b0;

    memory_writeback_cycle #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_m   (valid_m),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .ResultSrcM(ResultSrcM),
        .RD_M      (RD_M),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .StallM    (StallM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .RegWriteW (RegWriteW),
        .RDW       (RDW),
        .ResultW   (ResultW),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one instruction starting at a negedge and returns at the negedge
    // after the cycle in which it was consumed. ack_at = k acks on the k-th
    // access cycle; 0 never acks.
    task automatic apply_stimulus(input logic v, input logic rw, input logic mw, input logic rs,
                                  input logic [4:0] rd, input logic [DATA_W-1:0] alu,
                                  input logic [DATA_W-1:0] wd, input int ack_at,
                                  input logic [DATA_W-1:0] rdata);
        logic is_mem;
        logic is_store;
        bit   done;
        valid_m    = v;
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = rs;
        RD_M       = rd;
        ALUResultM = alu;
        WriteDataM = wd;
        is_mem     = v & (mw | rs);
        is_store   = mw;
        if (!is_mem) begin
            // An ack seen outside an access must be ignored.
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = DATA_W'($urandom);
            #1 check_output("stall_nonmem", StallM, 0);
            if (v && rw) exp_q.push_back('{rd: rd, val: alu});
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
        end else begin
            mem_ack = 1'b0;
            #1 check_output("stall_issue", StallM, 1);
            @(posedge clk);
            @(negedge clk);
            done = 0;
            for (int c = 1; c <= TIMEOUT && !done; c++) begin
                check_output("mem_req_hi", mem_req, 1);
                check_output("mem_addr", mem_addr, alu[ADDR_W-1:0]);
                check_output("mem_we", mem_we, is_store);
                check_output("mem_wdata", mem_wdata, wd);
                if (c == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                    #1 check_output("stall_ack", StallM, 0);
                    if (!is_store && rw) exp_q.push_back('{rd: rd, val: rdata});
                    done = 1;
                end else if (c == TIMEOUT) begin
                    #1 check_output("stall_timeout", StallM, 0);
                    err_expected++;
                    done = 1;
                end else begin
                    #1 check_output("stall_wait", StallM, 1);
                end
                @(posedge clk);
                @(negedge clk);
                mem_ack = 1'b0;
            end
            check_output("mem_req_lo", mem_req, 0);
        end
    endtask

    task automatic idle_cycles(input int n);
        valid_m = 1'b0;
        mem_ack = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every writeback pulse must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && RegWriteW) begin
                prev_wb = last_wb;
                last_wb = cycle;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_wb: got rd=%0d val=%h expected none", RDW, ResultW);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    check_output("wb_rd", RDW, e.rd);
                    check_output("wb_val", ResultW, e.val);
                end
            end
            if (err_o) begin
                err_seen++;
                check_output("err_single_pulse", err_prev, 0);
            end
            err_prev = err_o;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        @(negedge clk);
        check_output("rst_regwrite", RegWriteW, 0);
        check_output("rst_mem_req", mem_req, 0);
        check_output("rst_mem_we", mem_we, 0);
        check_output("rst_err", err_o, 0);
        check_output("rst_rdw", RDW, 0);
        check_output("rst_result", ResultW, 0);
        check_output("rst_addr", mem_addr, 0);
        check_output("rst_wdata", mem_wdata, 0);
        check_output("rst_stall", StallM, 0);
        rst = 1'b1;
        @(negedge clk);

        // ALU op, then a bubble that must leave RDW/ResultW untouched.
        apply_stimulus(1, 1, 0, 0, 5'd5, 18'h00ABC, 18'h0, 0, 18'h0);
        apply_stimulus(0, 1, 0, 0, 5'd9, 18'h12345, 18'h0, 0, 18'h0);
        check_output("bubble_regwrite", RegWriteW, 0);
        check_output("bubble_rdw_hold", RDW, 5'd5);
        check_output("bubble_result_hold", ResultW, 18'h00ABC);

        // Load acked on the 3rd access cycle.
        apply_stimulus(1, 1, 0, 1, 5'd7, 18'h00123, 18'h0, 3, 18'h3FFFF);
        // Store acked immediately.
        apply_stimulus(1, 1, 1, 0, 5'd2, 18'h001FF, 18'h15555, 1, 18'h0);
        // Timeout, then a normal ALU op.
        apply_stimulus(1, 1, 0, 1, 5'd4, 18'h00044, 18'h0, 0, 18'h0);
        apply_stimulus(1, 1, 0, 0, 5'd6, 18'h00066, 18'h0, 0, 18'h0);
        // Ack on the last allowed cycle beats the timeout.
        apply_stimulus(1, 1, 0, 1, 5'd8, 18'h00088, 18'h0, TIMEOUT, 18'h2AAAA);
        idle_cycles(2);

        // Reset during the 2nd access cycle of a load.
        valid_m    = 1'b1;
        RegWriteM  = 1'b1;
        MemWriteM  = 1'b0;
        ResultSrcM = 1'b1;
        RD_M       = 5'd11;
        ALUResultM = 18'h00011;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("arst_mem_req", mem_req, 0);
        check_output("arst_regwrite", RegWriteW, 0);
        check_output("arst_stall", StallM, 0);
        check_output("arst_err", err_o, 0);
        valid_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(1, 1, 0, 1, 5'd12, 18'h00021, 18'h0, 2, 18'h0BEEF);

        // Back-to-back load then ALU op: writebacks one cycle apart.
        apply_stimulus(1, 1, 0, 1, 5'd13, 18'h00031, 18'h0, 2, 18'h01234);
        apply_stimulus(1, 1, 0, 0, 5'd3, 18'h00010, 18'h0, 0, 18'h0);
        idle_cycles(2);
        check_output("b2b_gap", last_wb - prev_wb, 1);

        // Randomized mix.
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                           1'($urandom), 5'($urandom), DATA_W'($urandom),
                           DATA_W'($urandom), int'($urandom_range(0, TIMEOUT)),
                           DATA_W'($urandom));
        end
        idle_cycles(3);

        check_output("wb_queue_empty", exp_q.size(), 0);
        check_output("err_count", err_seen, err_expected);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
